// File: rtl/fft_pkg.sv
// Shared constants and the bank-state type for the FFT frame packer.
package fft_pkg;

  localparam int N_PTS       = 8;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_W     = 256;
  localparam int SCALE_SHIFT = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } bank_state_e;

endpackage

// File: rtl/fft_valid_delay.sv
// Fixed-depth valid pipe: out_v is in_v delayed by DEPTH clock cycles.
module fft_valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_v,
  output logic out_v
);

  logic [DEPTH-1:0] pipe;

  // Shift the strobe one stage per cycle; reset empties the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | DEPTH'(in_v);
    end
  end

  assign out_v = pipe[DEPTH-1];

endmodule

// File: rtl/fft_frame_packer.sv
// Packs a stream of complex samples into 8-point, 256-bit frames for the FFT
// stage using two ping-pong banks. Frames issue oldest first, spaced by at
// least MIN_GAP idle cycles of fft_en.
//
// Build option: define FFT_PACK_SCALE_EN to arithmetic-shift each component
// right by SCALE_SHIFT before storing it (growth headroom for the FFT).
//
// Handshake: a sample transfers on a rising edge where in_valid and in_ready
// are both high; in_ready depends only on registered bank state, never on
// in_valid, and drops only while both banks hold complete frames.
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int N_PTS    = 8,
  parameter int SAMPLE_W = 16,
  parameter int MIN_GAP  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [SAMPLE_W-1:0] in_re,
  input  logic [SAMPLE_W-1:0] in_im,
  output logic [FRAME_W-1:0]  fft_d,
  output logic                fft_en,
  output logic                fft_dout_valid,
  output logic                drop_err,
  output logic [3:0]          dbg_bank_state
);

  localparam int       SLOT_W = 2 * SAMPLE_W;
  localparam bit [2:0] LAST   = 3'(N_PTS - 1);

  bank_state_e          bank_st  [2];
  logic [FRAME_W-1:0]   bank_d   [2];
  logic [FRAME_W-1:0]   bank_nxt [2];
  logic                 fill_sel;     // bank receiving samples
  logic                 issue_ptr;    // oldest bank not yet issued
  logic                 issued_bank;  // bank shown on fft_d while fft_en=1
  logic [2:0]           wcnt;
  logic [3:0]           gap_cnt;
  logic [SAMPLE_W-1:0]  re_s;
  logic [SAMPLE_W-1:0]  im_s;
  logic [2:0]           wr_idx;
  logic                 accept;
  logic                 wr_last;
  logic                 cand_full;
  logic                 issue_now;

`ifdef FFT_PACK_SCALE_EN
  assign re_s = $signed(in_re) >>> SCALE_SHIFT;
  assign im_s = $signed(in_im) >>> SCALE_SHIFT;
`else
  assign re_s = in_re;
  assign im_s = in_im;
`endif

  assign in_ready       = !((bank_st[0] == FULL) && (bank_st[1] == FULL));
  assign accept         = in_valid && in_ready;
  // A start-of-frame sample always lands in slot 0 of the current fill bank.
  assign wr_idx         = in_sof ? 3'd0 : wcnt;
  assign wr_last        = accept && (wr_idx == LAST);
  // The oldest bank may be completing on this very edge; it can issue at once.
  assign cand_full      = (bank_st[issue_ptr] == FULL) ||
                          (wr_last && (fill_sel == issue_ptr));
  assign issue_now      = cand_full && (gap_cnt == 4'd0);
  assign dbg_bank_state = {bank_st[1], bank_st[0]};

  // Bank contents after this edge's write, so a completing bank can be issued
  // with its final sample already merged.
  always_comb begin
    bank_nxt[0] = bank_d[0];
    bank_nxt[1] = bank_d[1];
    if (accept) begin
      bank_nxt[fill_sel][int'(wr_idx)*SLOT_W +: SLOT_W] = {re_s, im_s};
    end
  end

  // Bank state, write counter, issue pointer, gap timer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_st[0]  <= EMPTY;
      bank_st[1]  <= EMPTY;
      bank_d[0]   <= '0;
      bank_d[1]   <= '0;
      fill_sel    <= 1'b0;
      issue_ptr   <= 1'b0;
      issued_bank <= 1'b0;
      wcnt        <= 3'd0;
      gap_cnt     <= 4'd0;
      fft_d       <= '0;
      fft_en      <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        // A bank stays FULL for the cycle its frame is on fft_d, then frees.
        if (fft_en && (issued_bank == 1'(b))) begin
          bank_st[b] <= EMPTY;
        end else if (accept && (fill_sel == 1'(b))) begin
          bank_st[b] <= wr_last ? FULL : FILL;
        end
      end
      bank_d[0] <= bank_nxt[0];
      bank_d[1] <= bank_nxt[1];
      if (accept) begin
        wcnt <= wr_idx + 3'd1;
        if (in_sof && (wcnt != 3'd0)) begin
          drop_err <= 1'b1;
        end
      end
      if (wr_last) begin
        fill_sel <= ~fill_sel;
      end
      fft_en <= issue_now;
      if (issue_now) begin
        fft_d       <= bank_nxt[issue_ptr];
        issued_bank <= issue_ptr;
        issue_ptr   <= ~issue_ptr;
        gap_cnt     <= 4'(MIN_GAP);
      end else if (gap_cnt != 4'd0) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  fft_valid_delay #(.DEPTH(2)) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .in_v  (fft_en),
    .out_v (fft_dout_valid)
  );

endmodule
